// File: rtl/hbm_rsp_latency_sched.sv
// In-order fixed-latency response scheduler for the HBM endpoint model, with per-ID and total caps.
// Optional statistics (stall_cnt_o, max_occ_o) are built only when HBM_RSP_SCHED_STATS_EN is defined.

module hbm_rsp_latency_sched #(
    parameter int Latency      = 100,
    parameter int Depth        = 32,
    parameter int IdWidth      = 4,
    parameter int MaxTxnsPerId = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IdWidth-1:0]      req_id_i,
    input  logic                    req_write_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IdWidth-1:0]      rsp_id_o,
    output logic                    rsp_write_o,
    output logic                    busy_o,
    output logic [31:0]             stall_cnt_o,
    output logic [$clog2(Depth):0]  max_occ_o
);

    localparam int NumIds = 2 ** IdWidth;
    localparam int PtrW   = $clog2(Depth);
    localparam int OccW   = PtrW + 1;
    localparam int AgeW   = $clog2(Latency + 1);
    localparam int CntW   = $clog2(MaxTxnsPerId + 1);

    localparam logic [AgeW-1:0] AgeMax  = AgeW'(Latency);
    localparam logic [OccW-1:0] OccFull = OccW'(Depth);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxTxnsPerId);

    if (Latency < 1) begin : g_bad_latency
        $error("hbm_rsp_latency_sched: Latency must be >= 1");
    end
    if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $error("hbm_rsp_latency_sched: Depth must be a power of two >= 2");
    end
    if ((MaxTxnsPerId < 1) || (MaxTxnsPerId > Depth)) begin : g_bad_max_txns
        $error("hbm_rsp_latency_sched: MaxTxnsPerId must be in 1..Depth");
    end

    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [OccW-1:0]    occ_q, occ_d;
    logic               accept, pop;

    logic [IdWidth-1:0] ent_id  [Depth];
    logic               ent_wr  [Depth];
    logic [AgeW-1:0]    ent_age [Depth];
    logic               ent_vld [Depth];
    logic [CntW-1:0]    id_cnt  [NumIds];

    logic [AgeW-1:0]    head_age;

    // Both channels transfer on valid && ready. Ready is a function of registered
    // state and the offered ID only, so a pop never opens the request port in
    // the same cycle; once rsp_valid_o rises it holds until rsp_ready_i.
    assign req_ready_o = !rst_i && (occ_q != OccFull) && (id_cnt[req_id_i] != CntMax);
    assign accept      = req_valid_i && req_ready_o;

    assign head_age    = ent_age[rptr_q];
    assign rsp_valid_o = (occ_q != '0) && (head_age == AgeMax);
    assign rsp_id_o    = (occ_q != '0) ? ent_id[rptr_q] : '0;
    assign rsp_write_o = (occ_q != '0) ? ent_wr[rptr_q] : 1'b0;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign busy_o      = (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            occ_q <= occ_d;
            if (accept) wptr_q <= wptr_q + 1'b1;
            if (pop)    rptr_q <= rptr_q + 1'b1;
        end
    end

    // Each slot ages independently and saturates at Latency, so an arbitrarily
    // long consumer stall leaves matured entries parked without wrap-around.
    for (genvar g = 0; g < Depth; g++) begin : g_entry
        logic [IdWidth-1:0] id_q;
        logic               wr_q;
        logic [AgeW-1:0]    age_q;
        logic               vld_q;
        logic               wr_hit, rd_hit;

        assign wr_hit = accept && (wptr_q == PtrW'(g));
        assign rd_hit = pop && (rptr_q == PtrW'(g));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                id_q  <= '0;
                wr_q  <= 1'b0;
                age_q <= '0;
                vld_q <= 1'b0;
            end else if (wr_hit) begin
                id_q  <= req_id_i;
                wr_q  <= req_write_i;
                age_q <= '0;
                vld_q <= 1'b1;
            end else begin
                if (vld_q && (age_q < AgeMax)) age_q <= age_q + 1'b1;
                if (rd_hit) vld_q <= 1'b0;
            end
        end

        assign ent_id[g]  = id_q;
        assign ent_wr[g]  = wr_q;
        assign ent_age[g] = age_q;
        assign ent_vld[g] = vld_q;
    end

    for (genvar k = 0; k < NumIds; k++) begin : g_id_cnt
        logic [CntW-1:0] cnt_q;
        logic            inc, dec;

        assign inc = accept && (req_id_i == IdWidth'(k));
        assign dec = pop && (rsp_id_o == IdWidth'(k));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (inc && !dec) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (dec && !inc) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign id_cnt[k] = cnt_q;
    end

`ifdef HBM_RSP_SCHED_STATS_EN
    logic [31:0]     stall_q;
    logic [OccW-1:0] max_occ_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q   <= '0;
            max_occ_q <= '0;
        end else begin
            if (req_valid_i && !req_ready_o && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (occ_d > max_occ_q) max_occ_q <= occ_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign max_occ_o   = max_occ_q;
`else
    assign stall_cnt_o = '0;
    assign max_occ_o   = '0;
`endif

    a_no_cnt_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> (id_cnt[req_id_i] != CntMax));

    a_no_cnt_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> (id_cnt[rsp_id_o] != '0));

    a_head_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_o |-> ent_vld[rptr_q]);

    a_rsp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=>
            (rsp_valid_o && $stable(rsp_id_o) && $stable(rsp_write_o)));

endmodule

// File: tb/tb_hbm_rsp_latency_sched.sv
// Directed bench for hbm_rsp_latency_sched: latency, per-ID cap, full-queue stall,
// same-ID accept/pop overlap and mid-operation reset.

module tb_hbm_rsp_latency_sched;

  localparam int Latency  = 100;
  localparam int Depth    = 32;
  localparam int IdWidth  = 4;
  localparam int OccW     = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [IdWidth-1:0] req_id;
  logic               req_write;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IdWidth-1:0] rsp_id;
  logic               rsp_write;
  logic               busy;
  logic [31:0]        stall_cnt;
  logic [OccW-1:0]    max_occ;

  int errors = 0;
  int checks = 0;

  logic [IdWidth:0] exp_q[$];

  always #5 clk = ~clk;

  hbm_rsp_latency_sched #(
    .Latency(Latency), .Depth(Depth), .IdWidth(IdWidth), .MaxTxnsPerId(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_id_i(req_id), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_write_o(rsp_write),
    .busy_o(busy), .stall_cnt_o(stall_cnt), .max_occ_o(max_occ)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_id = '0; req_write = 1'b0; rsp_ready = 1'b0;
    repeat (3) step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %0b want 0", req_ready); end
    rst = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if ({rsp_write, rsp_id} !== 5'd0) begin errors++; $display("FAIL reset_payload: got %0h want 0", {rsp_write, rsp_id}); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (max_occ !== 6'd0) begin errors++; $display("FAIL reset_max_occ: got %0d want 0", max_occ); end
  endtask

  task automatic test_single_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_id = 4'd3; req_write = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    repeat (Latency - 1) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early: rsp_valid=%0b want 0 at latency-1", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1 at latency", rsp_valid); end
    checks++; if (rsp_id !== 4'd3) begin errors++; $display("FAIL single_id: got %0d want 3", rsp_id); end
    checks++; if (rsp_write !== 1'b0) begin errors++; $display("FAIL single_write: got %0b want 0", rsp_write); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: rsp_valid=%0b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_per_id_limit();
    int ready_at = -1;
    int first_rsp = -1;
    int pops = 0;
    logic [IdWidth:0] e;
    rsp_ready = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_id = 4'd5; req_write = k[0];
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL id5_accept_%0d: ready=%0b want 1", k, req_ready); end
      exp_q.push_back({k[0], 4'd5});
      step();
    end
    req_write = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL id5_fifth_blocked: ready=%0b want 0", req_ready); end
    for (int i = 1; i <= 260; i++) begin
      step();
      if (req_valid && ready_at >= 0) req_valid = 1'b0;
      else if (req_valid && req_ready) begin
        ready_at = i;
        exp_q.push_back({1'b0, 4'd5});
      end
      if (rsp_valid) begin
        pops++;
        if (first_rsp < 0) first_rsp = i;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL id5_rsp_extra: got %0h want none", {rsp_write, rsp_id});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_write, rsp_id} !== e) begin errors++; $display("FAIL id5_rsp_order: got %0h want %0h", {rsp_write, rsp_id}, e); end
        end
      end
      if (ready_at >= 0 && !req_valid && !busy) break;
    end
    checks++; if (ready_at !== 98) begin errors++; $display("FAIL id5_ready_return: cycle %0d want 98", ready_at); end
    checks++; if (first_rsp !== 97) begin errors++; $display("FAIL id5_first_rsp: cycle %0d want 97", first_rsp); end
    checks++; if (pops !== 5) begin errors++; $display("FAIL id5_pop_count: got %0d want 5", pops); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id5_drained: busy=%0b want 0", busy); end
`ifdef HBM_RSP_SCHED_STATS_EN
    checks++; if (stall_cnt !== 32'd98) begin errors++; $display("FAIL id5_stall_cnt: got %0d want 98", stall_cnt); end
`else
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL id5_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_fill_stall();
    int bad_ready = 0;
    logic [IdWidth:0] e;
    logic [4:0] kk;
    rsp_ready = 1'b0;
    exp_q.delete();
    for (int k = 0; k < Depth; k++) begin
      kk = 5'(k);
      req_valid = 1'b1; req_id = kk[3:0]; req_write = kk[2];
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_accept_%0d: ready=%0b want 1", k, req_ready); end
      exp_q.push_back({kk[2], kk[3:0]});
      step();
    end
    req_id = 4'd7; req_write = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %0b want 0", req_ready); end
    repeat (300) begin
      step();
      if (req_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL fill_stall_ready: ready high %0d cycles want 0", bad_ready); end
`ifdef HBM_RSP_SCHED_STATS_EN
    checks++; if (max_occ !== 6'd32) begin errors++; $display("FAIL fill_max_occ: got %0d want 32", max_occ); end
`else
    checks++; if (max_occ !== 6'd0) begin errors++; $display("FAIL fill_max_occ: got %0d want 0", max_occ); end
`endif
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_no_ready_through: got %0b want 0", req_ready); end
    for (int k = 0; k < Depth; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_write, rsp_id} !== e) begin
        errors++; $display("FAIL fill_drain_%0d: valid=%0b payload=%0h want 1/%0h", k, rsp_valid, {rsp_write, rsp_id}, e);
      end
      step();
      if (k == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %0b want 1", req_ready); end
      end
    end
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: busy=%0b valid=%0b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_same_id_swap();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_id = 4'd2; req_write = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL swap_first_ready: got %0b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    repeat (Latency) step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd2) begin errors++; $display("FAIL swap_head: valid=%0b id=%0d want 1/2", rsp_valid, rsp_id); end
    req_valid = 1'b1; req_id = 4'd2; req_write = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL swap_ready: got %0b want 1", req_ready); end
    step();
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL swap_occ: busy=%0b valid=%0b want 1/0", busy, rsp_valid); end
    req_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL swap_fill_%0d: ready=%0b want 1", k, req_ready); end
      step();
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL swap_id_cap: ready=%0b want 0", req_ready); end
    req_valid = 1'b0;
    repeat (Latency - 4) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL swap_early: rsp_valid=%0b want 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd2 || rsp_write !== 1'b1) begin
      errors++; $display("FAIL swap_rsp: valid=%0b id=%0d write=%0b want 1/2/1", rsp_valid, rsp_id, rsp_write);
    end
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swap_drained: busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    logic [IdWidth:0] got = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_id = 4'(k); req_write = 1'b0;
      step();
    end
    req_valid = 1'b0;
    repeat (30) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %0b want 0", req_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: busy=%0b valid=%0b want 0/0", busy, rsp_valid); end
    repeat (9) step();
    req_valid = 1'b1; req_id = 4'd9; req_write = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (rsp_valid) begin
        first = i; got = {rsp_write, rsp_id};
        break;
      end
    end
    checks++; if (first !== Latency) begin errors++; $display("FAIL rst_mid_latency: first rsp at %0d want %0d", first, Latency); end
    checks++; if (got !== {1'b1, 4'd9}) begin errors++; $display("FAIL rst_mid_payload: got %0h want 19", got); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_drained: busy=%0b want 0", busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_per_id_limit();
    test_fill_stall();
    test_same_id_swap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
